// File: rtl/traffic_light_seq_pkg.sv
// ============================================================================
// Module   : traffic_pkg
// Brief    : Shared phase, light and status encodings for the traffic sequencer
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NS_G  = 3'd1,
        NS_Y  = 3'd2,
        AR1   = 3'd3,
        EW_G  = 3'd4,
        EW_Y  = 3'd5,
        AR2   = 3'd6,
        BLINK = 3'd7
    } phase_e;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_NS    = 2'b01;
    localparam logic [1:0] ST_EW    = 2'b10;
    localparam logic [1:0] ST_BLINK = 2'b11;

    localparam int CTL_EN    = 0;
    localparam int CTL_BLINK = 1;
    localparam int CTL_HOLD  = 2;

    function automatic phase_e next_timed(input phase_e s);
        phase_e n;
        case (s)
            NS_G:    n = NS_Y;
            NS_Y:    n = AR1;
            AR1:     n = EW_G;
            EW_G:    n = EW_Y;
            EW_Y:    n = AR2;
            default: n = NS_G;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] stat_of(input phase_e s);
        logic [1:0] r;
        case (s)
            NS_G, NS_Y, AR1: r = ST_NS;
            EW_G, EW_Y, AR2: r = ST_EW;
            BLINK:           r = ST_BLINK;
            default:         r = ST_IDLE;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] at_least_one(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_light_seq_if.sv
// ============================================================================
// Module   : traffic_light_seq_if
// Brief    : Control/timer inputs and light/status outputs of the sequencer
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface traffic_light_seq_if;
    logic [3:0]  ctl;
    logic [31:0] timer_0;
    logic [31:0] timer_1;
    logic [2:0]  ns_light;
    logic [2:0]  ew_light;
    logic [1:0]  stat;
    logic        phase_done;

    modport master (
        output ctl, timer_0, timer_1,
        input  ns_light, ew_light, stat, phase_done
    );

    modport slave (
        input  ctl, timer_0, timer_1,
        output ns_light, ew_light, stat, phase_done
    );
endinterface

`default_nettype wire

// File: rtl/traffic_light_seq_tick_gen.sv
// ============================================================================
// Module   : tick_gen
// Brief    : Timing-tick prescaler; tick_o is high on the last count of a period
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  wire logic pclk,
    input  wire logic preset,
    input  wire logic restart_i,
    input  wire logic en_i,
    output logic      tick_o
);
    localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/traffic_light_seq.sv
// ============================================================================
// Module   : traffic_light_seq
// Brief    : Timed NS/EW signal-head sequencer with hold, blink and idle modes
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_light_seq
    import traffic_pkg::*;
#(
    parameter int TICK_DIV     = 1,
    parameter int ALLRED_TICKS = 2,
    parameter int BLINK_TICKS  = 4
) (
    input  wire logic           pclk,
    input  wire logic           preset,
    traffic_light_seq_if.slave  bus
);
    phase_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        blink_on_q, blink_on_d;
    logic [2:0]  ns_q, ns_d, ew_q, ew_d;
    logic [1:0]  stat_q, stat_d;
    logic        done_q, done_d;

    logic        w_tick, w_tick_en, w_restart;
    logic        w_en, w_blink, w_hold;
    logic        w_unused_ctl;

    assign w_en         = bus.ctl[CTL_EN];
    assign w_blink      = bus.ctl[CTL_BLINK];
    assign w_hold       = bus.ctl[CTL_HOLD];
    assign w_unused_ctl = bus.ctl[3];

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .pclk      (pclk),
        .preset    (preset),
        .restart_i (w_restart),
        .en_i      (w_tick_en),
        .tick_o    (w_tick)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        blink_on_d = blink_on_q;
        done_d     = 1'b0;
        w_restart  = 1'b0;
        w_tick_en  = 1'b0;

        if (!w_en) begin
            state_d    = IDLE;
            cnt_d      = 32'd0;
            blink_on_d = 1'b0;
            w_restart  = 1'b1;
        end else if (w_blink) begin
            if (state_q != BLINK) begin
                state_d    = BLINK;
                cnt_d      = at_least_one(32'(BLINK_TICKS));
                blink_on_d = 1'b1;
                w_restart  = 1'b1;
            end else begin
                w_tick_en = 1'b1;
                if (w_tick) begin
                    if (cnt_q <= 32'd1) begin
                        cnt_d      = at_least_one(32'(BLINK_TICKS));
                        blink_on_d = ~blink_on_q;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
            end
        end else if (!w_hold) begin
            case (state_q)
                IDLE: begin
                    state_d   = NS_G;
                    cnt_d     = at_least_one(bus.timer_0);
                    w_restart = 1'b1;
                end
                // Leaving blink always clears through all-red before EW green.
                BLINK: begin
                    state_d    = AR1;
                    cnt_d      = at_least_one(32'(ALLRED_TICKS));
                    blink_on_d = 1'b0;
                    w_restart  = 1'b1;
                end
                default: begin
                    w_tick_en = 1'b1;
                    if (w_tick) begin
                        if (cnt_q <= 32'd1) begin
                            state_d   = next_timed(state_q);
                            done_d    = 1'b1;
                            w_restart = 1'b1;
                            case (next_timed(state_q))
                                NS_G, EW_G: cnt_d = at_least_one(bus.timer_0);
                                NS_Y, EW_Y: cnt_d = at_least_one(bus.timer_1);
                                default:    cnt_d = at_least_one(32'(ALLRED_TICKS));
                            endcase
                        end else begin
                            cnt_d = cnt_q - 32'd1;
                        end
                    end
                end
            endcase
        end

        ns_d = L_RED;
        ew_d = L_RED;
        case (state_d)
            NS_G:  ns_d = L_GRN;
            NS_Y:  ns_d = L_YEL;
            EW_G:  ew_d = L_GRN;
            EW_Y:  ew_d = L_YEL;
            BLINK: begin
                ns_d = blink_on_d ? L_YEL : L_OFF;
                ew_d = blink_on_d ? L_YEL : L_OFF;
            end
            default: ;
        endcase
        stat_d = stat_of(state_d);
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q    <= IDLE;
            cnt_q      <= 32'd0;
            blink_on_q <= 1'b0;
            ns_q       <= L_RED;
            ew_q       <= L_RED;
            stat_q     <= ST_IDLE;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            blink_on_q <= blink_on_d;
            ns_q       <= ns_d;
            ew_q       <= ew_d;
            stat_q     <= stat_d;
            done_q     <= done_d;
        end
    end

    assign bus.ns_light   = ns_q;
    assign bus.ew_light   = ew_q;
    assign bus.stat       = stat_q;
    assign bus.phase_done = done_q;

    a_no_conflict: assert property (@(posedge pclk) disable iff (preset)
        (state_q != BLINK) |-> (ns_q == L_RED || ew_q == L_RED));

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_seq.sv
// ============================================================================
// Module   : tb_traffic_light_seq
// Brief    : Random + directed check of two sequencer instances (TICK_DIV 1 and 4)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_traffic_light_seq;
    localparam int ALLRED = 2;
    localparam int BLINKT = 4;

    localparam int P_IDLE = 0, P_NSG = 1, P_NSY = 2, P_AR1 = 3;
    localparam int P_EWG = 4, P_EWY = 5, P_AR2 = 6, P_BLINK = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    traffic_light_seq_if if1 ();
    traffic_light_seq_if if4 ();

    traffic_light_seq #(.TICK_DIV(1), .ALLRED_TICKS(ALLRED), .BLINK_TICKS(BLINKT)) dut1 (
        .pclk(clk), .preset(rst), .bus(if1)
    );
    traffic_light_seq #(.TICK_DIV(4), .ALLRED_TICKS(ALLRED), .BLINK_TICKS(BLINKT)) dut4 (
        .pclk(clk), .preset(rst), .bus(if4)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Model: phase, active cycles spent in it, and its length in cycles.
    int     m_ph  [2];
    longint m_el  [2];
    longint m_dur [2];
    bit     m_done[2];

    logic [3:0]  s_ctl;
    logic [31:0] s_t0, s_t1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic longint div_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic longint ticks_of(input int ph, input logic [31:0] t0, input logic [31:0] t1);
        longint v;
        if (ph == P_NSG || ph == P_EWG)      v = longint'(t0);
        else if (ph == P_NSY || ph == P_EWY) v = longint'(t1);
        else                                 v = ALLRED;
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = P_IDLE; m_el[k] = 0; m_dur[k] = 0; m_done[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        m_done[k] = 1'b0;
        if (!s_ctl[0]) begin
            m_ph[k] = P_IDLE; m_el[k] = 0;
        end else if (s_ctl[1]) begin
            if (m_ph[k] != P_BLINK) begin m_ph[k] = P_BLINK; m_el[k] = 0; end
            else m_el[k]++;
        end else if (s_ctl[2]) begin
        end else if (m_ph[k] == P_IDLE) begin
            m_ph[k] = P_NSG; m_el[k] = 0;
            m_dur[k] = ticks_of(P_NSG, s_t0, s_t1) * div_of(k);
        end else if (m_ph[k] == P_BLINK) begin
            m_ph[k] = P_AR1; m_el[k] = 0;
            m_dur[k] = ticks_of(P_AR1, s_t0, s_t1) * div_of(k);
        end else begin
            m_el[k]++;
            if (m_el[k] == m_dur[k]) begin
                m_ph[k] = (m_ph[k] == P_AR2) ? P_NSG : m_ph[k] + 1;
                m_el[k] = 0;
                m_dur[k] = ticks_of(m_ph[k], s_t0, s_t1) * div_of(k);
                m_done[k] = 1'b1;
            end
        end
    endtask

    task automatic expect_out(input int k, output logic [2:0] ns, output logic [2:0] ew,
                              output logic [1:0] st);
        bit on;
        ns = 3'b100; ew = 3'b100; st = 2'b00;
        on = ((m_el[k] / (BLINKT * div_of(k))) % 2) == 0;
        case (m_ph[k])
            P_NSG: begin ns = 3'b001; st = 2'b01; end
            P_NSY: begin ns = 3'b010; st = 2'b01; end
            P_AR1: st = 2'b01;
            P_EWG: begin ew = 3'b001; st = 2'b10; end
            P_EWY: begin ew = 3'b010; st = 2'b10; end
            P_AR2: st = 2'b10;
            P_BLINK: begin ns = on ? 3'b010 : 3'b000; ew = ns; st = 2'b11; end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        logic [2:0] ns, ew;
        logic [1:0] st;
        expect_out(0, ns, ew, st);
        check_eq("div1_ns", 32'(if1.ns_light), 32'(ns));
        check_eq("div1_ew", 32'(if1.ew_light), 32'(ew));
        check_eq("div1_stat", 32'(if1.stat), 32'(st));
        check_eq("div1_done", 32'(if1.phase_done), 32'(m_done[0]));
        expect_out(1, ns, ew, st);
        check_eq("div4_ns", 32'(if4.ns_light), 32'(ns));
        check_eq("div4_ew", 32'(if4.ew_light), 32'(ew));
        check_eq("div4_stat", 32'(if4.stat), 32'(st));
        check_eq("div4_done", 32'(if4.phase_done), 32'(m_done[1]));
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] t0, input logic [31:0] t1);
        s_ctl = c; s_t0 = t0; s_t1 = t1;
        if1.ctl = c; if1.timer_0 = t0; if1.timer_1 = t1;
        if4.ctl = c; if4.timer_0 = t0; if4.timer_1 = t1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rst) model_reset();
            else begin model_step(0); model_step(1); end
            compare_all();
        end
    endtask

    task automatic run_until(input int ph, input int budget, input string tag);
        int c = 0;
        while (m_ph[0] != ph && c < budget) begin run(1); c++; end
        check_eq(tag, 32'(m_ph[0] == ph), 32'd1);
    endtask

    initial begin
        logic [3:0]  c;
        logic [31:0] t0, t1;
        model_reset();
        drive(4'b0000, 32'd3, 32'd2);
        run(3);
        check_eq("rst_ns", 32'(if1.ns_light), 32'h4);
        check_eq("rst_stat", 32'(if4.stat), 32'h0);
        rst = 1'b0;

        // Basic cycle, then hold during EW green, then blink and return.
        drive(4'b0001, 32'd3, 32'd2);
        run(40);
        run_until(P_EWG, 40, "wait_ewg");
        drive(4'b0101, 32'd3, 32'd2);
        run(10);
        drive(4'b0001, 32'd3, 32'd2);
        run(30);
        run_until(P_NSG, 40, "wait_nsg");
        drive(4'b0011, 32'd3, 32'd2);
        run(45);
        drive(4'b0001, 32'd3, 32'd2);
        run(20);

        // Timer change mid-green and zero-length green.
        run_until(P_NSG, 40, "wait_nsg2");
        drive(4'b0001, 32'd6, 32'd2);
        run(40);
        drive(4'b0001, 32'd0, 32'd0);
        run(60);

        // Asynchronous reset in NS yellow.
        drive(4'b0001, 32'd3, 32'd2);
        run_until(P_NSY, 60, "wait_nsy");
        #3 rst = 1'b1;
        #1;
        check_eq("arst_ns", 32'(if1.ns_light), 32'h4);
        check_eq("arst_ew", 32'(if1.ew_light), 32'h4);
        check_eq("arst_stat", 32'(if1.stat), 32'h0);
        run(2);
        rst = 1'b0;
        run(1);
        check_eq("post_rst_nsg", 32'(if1.ns_light), 32'h1);

        for (int seg = 0; seg < 80; seg++) begin
            c[0] = ($urandom_range(0, 9) != 0);
            c[1] = ($urandom_range(0, 6) == 0);
            c[2] = ($urandom_range(0, 4) == 0);
            c[3] = $urandom_range(0, 1) == 1;
            t0 = (seg % 3 == 0) ? 32'($urandom_range(0, 5)) : s_t0;
            t1 = (seg % 4 == 0) ? 32'($urandom_range(0, 4)) : s_t1;
            drive(c, t0, t1);
            run($urandom_range(1, 25));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
